// File: rtl/pattern_pkg.sv
// pattern_pkg: shared encodings for the 101 pattern detector and its upstream serializer
//   ST_IDLE / ST_SHIFT : serializer one-hot FSM states
//   PAT_WORD_W         : default serializer word width
//   DET_*              : detector one-hot states, kept here so both stages share one source
package pattern_pkg;
    localparam int PAT_WORD_W = 8;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_SHIFT = 2'b10
    } ser_state_t;
    localparam int DET_STATE_W = 4;
    localparam logic [DET_STATE_W-1:0] DET_IDLE = 4'b0001;
    localparam logic [DET_STATE_W-1:0] DET_S1   = 4'b0010;
    localparam logic [DET_STATE_W-1:0] DET_S10  = 4'b0100;
    localparam logic [DET_STATE_W-1:0] DET_S101 = 4'b1000;
endpackage

// File: rtl/pattern_hold_reg.sv
// pattern_hold_reg: single-entry holding register in front of the serializer shifter
//   clk, rst  : clock, synchronous active-high reset
//   data_i    : word offered upstream, captured only when vld_i && ready_o
//   vld_i     : upstream valid
//   pop_i     : shifter takes the held word this edge
//   data_o    : held word
//   vld_o     : held word present
//   ready_o   : register empty, taken straight from the flag
module pattern_hold_reg
    import pattern_pkg::*;
#(
    parameter int WIDTH = PAT_WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             vld_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             vld_o,
    output logic             ready_o
);
    logic [WIDTH-1:0] data_q;
    logic             vld_q;
    // accept and pop never coincide: accept needs an empty register, pop a full one
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (vld_i && !vld_q) begin
            data_q <= data_i;
            vld_q  <= 1'b1;
        end else if (pop_i) begin
            vld_q  <= 1'b0;
        end
    end
    assign data_o  = data_q;
    assign vld_o   = vld_q;
    assign ready_o = !vld_q;
endmodule

// File: rtl/pattern_serializer.sv
// pattern_serializer: parallel-to-serial stage feeding the 101 pattern detector
//   clk, rst  : clock, synchronous active-high reset
//   in_data   : WIDTH-bit word, in_valid/in_ready handshake
//   bit_out   : registered serial bit (IDLE_BIT between words)
//   bit_valid : bit_out carries a payload bit
//   word_last : bit_out is the final bit of the word
//   busy      : shifter active or holding register occupied
// Define PATTERN_SER_PARITY_EN to append an even-parity bit after each word.
module pattern_serializer
    import pattern_pkg::*;
#(
    parameter int WIDTH     = PAT_WORD_W,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_last,
    output logic             busy
);
`ifdef PATTERN_SER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);
    localparam logic [CW-1:0] PEN  = CW'(NB - 2);
    ser_state_t       state_q;
    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    cnt_q;
    logic             bit_q, bv_q, last_q;
    logic [WIDTH-1:0] hold_data;
    logic             hold_vld, pop;
    logic             load_bit, sh_bit, nxt_bit;
    logic [WIDTH-1:0] load_sh, nxt_sh;
    pattern_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .data_i (in_data),
        .vld_i  (in_valid),
        .pop_i  (pop),
        .data_o (hold_data),
        .vld_o  (hold_vld),
        .ready_o(in_ready)
    );
    // reload on the edge after the current word's last bit, or straight from idle
    assign pop      = hold_vld && (state_q == ST_IDLE || cnt_q == LAST);
    // bit_q already holds the next bit out, so the shifter keeps only what remains
    assign load_bit = MSB_FIRST ? hold_data[WIDTH-1] : hold_data[0];
    assign load_sh  = MSB_FIRST ? {hold_data[WIDTH-2:0], 1'b0} : {1'b0, hold_data[WIDTH-1:1]};
    assign sh_bit   = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
    assign nxt_sh   = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
`ifdef PATTERN_SER_PARITY_EN
    logic par_q;
    always_ff @(posedge clk) begin
        if (rst) par_q <= 1'b0;
        else if (pop) par_q <= ^hold_data;
    end
    assign nxt_bit = (cnt_q == CW'(WIDTH - 1)) ? par_q : sh_bit;
`else
    assign nxt_bit = sh_bit;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            bit_q   <= IDLE_BIT;
            bv_q    <= 1'b0;
            last_q  <= 1'b0;
        end else if (pop) begin
            state_q <= ST_SHIFT;
            sh_q    <= load_sh;
            cnt_q   <= '0;
            bit_q   <= load_bit;
            bv_q    <= 1'b1;
            last_q  <= 1'b0;
        end else if (state_q == ST_SHIFT && cnt_q != LAST) begin
            sh_q    <= nxt_sh;
            cnt_q   <= cnt_q + 1'b1;
            bit_q   <= nxt_bit;
            last_q  <= (cnt_q == PEN);
        end else if (state_q == ST_SHIFT) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= IDLE_BIT;
            bv_q    <= 1'b0;
            last_q  <= 1'b0;
        end
    end
    assign bit_out   = bit_q;
    assign bit_valid = bv_q;
    assign word_last = last_q;
    assign busy      = (state_q == ST_SHIFT) || hold_vld;
endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: directed checks of the serializer, MSB-first and LSB-first instances
module tb_pattern_serializer;
    import pattern_pkg::*;
`ifdef PATTERN_SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, bit_out, bit_valid, word_last, busy;
    logic [7:0] d1_data = 8'h00;
    logic       d1_valid = 1'b0;
    logic       r1, b1, v1, l1, y1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .bit_out(bit_out), .bit_valid(bit_valid), .word_last(word_last), .busy(busy)
    );
    pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_data(d1_data), .in_valid(d1_valid), .in_ready(r1),
        .bit_out(b1), .bit_valid(v1), .word_last(l1), .busy(y1)
    );
    function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
        return (i >= 8) ? ^w : (msb ? w[7 - i] : w[i]);
    endfunction
    function automatic logic [3:0] det_next(input logic [3:0] s, input logic b);
        if (s == DET_IDLE) return b ? DET_S1 : DET_IDLE;
        if (s == DET_S1)   return b ? DET_S1 : DET_S10;
        if (s == DET_S10)  return b ? DET_S101 : DET_IDLE;
        return b ? DET_S1 : DET_S10;
    endfunction
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out got %b exp 0", bit_out); end
        checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid got %b exp 0", bit_valid); end
        checks++; if (word_last !== 1'b0) begin errors++; $display("FAIL reset_word_last got %b exp 0", word_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_single(input logic [7:0] w, input logic [7:0] mask);
        logic [3:0] ds;
        logic [7:0] m;
        ds = DET_IDLE;
        m = '0;
        @(negedge clk); in_data = w; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; in_data = 8'h00;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_%h_ready_held got %b exp 0", w, in_ready); end
        checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL single_%h_latency got %b exp 0", w, bit_valid); end
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            checks++; if (bit_valid !== 1'b1) begin errors++; $display("FAIL single_%h_valid[%0d] got %b exp 1", w, i, bit_valid); end
            checks++; if (bit_out !== exp_bit(w, i, 1'b1)) begin errors++; $display("FAIL single_%h_bit[%0d] got %b exp %b", w, i, bit_out, exp_bit(w, i, 1'b1)); end
            checks++; if (word_last !== (i == NB - 1)) begin errors++; $display("FAIL single_%h_last[%0d] got %b exp %b", w, i, word_last, i == NB - 1); end
            if (i < 8) begin
                ds = det_next(ds, bit_out);
                if (ds == DET_S101) m[i] = 1'b1;
            end
        end
        @(negedge clk);
        checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL single_%h_end_valid got %b exp 0", w, bit_valid); end
        checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL single_%h_end_bit got %b exp 0", w, bit_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_%h_end_busy got %b exp 0", w, busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_%h_end_ready got %b exp 1", w, in_ready); end
        checks++; if (m !== mask) begin errors++; $display("FAIL single_%h_detect got %b exp %b", w, m, mask); end
    endtask
    task automatic test_lsb_first();
        @(negedge clk); d1_data = 8'h01; d1_valid = 1'b1;
        @(negedge clk); d1_valid = 1'b0; d1_data = 8'h00;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL lsb_valid[%0d] got %b exp 1", i, v1); end
            checks++; if (b1 !== exp_bit(8'h01, i, 1'b0)) begin errors++; $display("FAIL lsb_bit[%0d] got %b exp %b", i, b1, exp_bit(8'h01, i, 1'b0)); end
            checks++; if (l1 !== (i == NB - 1)) begin errors++; $display("FAIL lsb_last[%0d] got %b exp %b", i, l1, i == NB - 1); end
        end
        @(negedge clk);
        checks++; if (v1 !== 1'b0 || y1 !== 1'b0) begin errors++; $display("FAIL lsb_end got valid=%b busy=%b exp 0 0", v1, y1); end
    endtask
    task automatic test_back_to_back();
        logic drop;
        int nl;
        logic [7:0] w;
        drop = 1'b0;
        nl = 0;
        @(negedge clk); in_data = 8'hA5; in_valid = 1'b1;
        @(negedge clk); in_data = 8'h0F;
        for (int i = 0; i < 2 * NB + 2; i++) begin
            @(negedge clk);
            if (drop) in_valid = 1'b0;
            drop = in_valid && in_ready;
            w = (i < NB) ? 8'hA5 : 8'h0F;
            if (word_last) nl++;
            if (i < 2 * NB) begin
                checks++; if (bit_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, bit_valid); end
                checks++; if (bit_out !== exp_bit(w, i % NB, 1'b1)) begin errors++; $display("FAIL b2b_bit[%0d] got %b exp %b", i, bit_out, exp_bit(w, i % NB, 1'b1)); end
            end else begin
                checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail_valid[%0d] got %b exp 0", i, bit_valid); end
            end
            checks++; if (word_last !== (i == NB - 1 || i == 2 * NB - 1)) begin errors++; $display("FAIL b2b_last[%0d] got %b exp %b", i, word_last, i == NB - 1 || i == 2 * NB - 1); end
            if (i >= 1 && i <= NB - 1) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low[%0d] got %b exp 0", i, in_ready); end
            end
        end
        in_valid = 1'b0;
        checks++; if (nl !== 2) begin errors++; $display("FAIL b2b_last_count got %0d exp 2", nl); end
    endtask
    task automatic test_ignore();
        logic [7:0] w;
        @(negedge clk); in_data = 8'hC3; in_valid = 1'b1;
        @(negedge clk); in_data = 8'h5A;
        for (int i = 0; i < 2 * NB + 4; i++) begin
            @(negedge clk);
            w = (i < NB) ? 8'hC3 : 8'h5A;
            if (i < 2 * NB) begin
                checks++; if (bit_valid !== 1'b1) begin errors++; $display("FAIL ignore_valid[%0d] got %b exp 1", i, bit_valid); end
                checks++; if (bit_out !== exp_bit(w, i % NB, 1'b1)) begin errors++; $display("FAIL ignore_bit[%0d] got %b exp %b", i, bit_out, exp_bit(w, i % NB, 1'b1)); end
            end else begin
                checks++; if (bit_valid !== 1'b0 || bit_out !== 1'b0) begin errors++; $display("FAIL ignore_tail[%0d] got valid=%b bit=%b exp 0 0", i, bit_valid, bit_out); end
            end
            // junk offered while hold is full, including on the edge the shifter reloads
            if (i >= 1 && i <= NB - 1) begin
                in_data = 8'hFF ^ 8'(i * 37);
                in_valid = 1'b1;
            end else if (i >= NB) begin
                in_valid = 1'b0;
            end
        end
    endtask
    task automatic test_reset_mid();
        @(negedge clk); in_data = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); in_valid = 1'b0; in_data = 8'h00;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_second_held got %b exp 0", in_ready); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", bit_valid); end
        checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL rstmid_bit got %b exp 0", bit_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        for (int i = 0; i < 2 * NB; i++) begin
            @(negedge clk);
            checks++; if (bit_out !== 1'b0 || bit_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet[%0d] got bit=%b valid=%b exp 0 0", i, bit_out, bit_valid); end
        end
    endtask
    initial begin
        test_reset();
        test_single(8'hA5, 8'b1000_0100);
        test_single(8'h07, 8'b0000_0000);
        test_lsb_first();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
